// File: rtl/udpport_encode.sv
// udpport_encode: serialises the 8-byte UDP header (src port, dst port,
// length, checksum) MSB-first onto the Ethernet TX byte stream, tagging each
// byte with its absolute frame position for the TX frame mux.
module udpport_encode #(
    parameter logic [7:0]  START = 8'h22,
    parameter logic [15:0] CSUM  = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] src_port,
    input  logic [15:0] dst_port,
    input  logic [15:0] payload_len,
    output logic [7:0]  eth_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_cnt,
    output logic        busy,
    output logic        done,
    output logic        len_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Largest payload whose UDP length (payload + 8) still fits in 16 bits.
    localparam logic [15:0] MAX_PAYLOAD = 16'hFFF7;

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_idx;
    logic [15:0] r_src;
    logic [15:0] r_dst;
    logic [15:0] r_len;
    logic        r_len_err;

    logic        w_len_ok;
    logic        w_accept;
    logic        w_reject;
    logic        w_xfer;
    logic [7:0]  w_byte;

    assign w_len_ok = (payload_len <= MAX_PAYLOAD);
    assign w_accept = (r_state == S_IDLE) && start && w_len_ok;
    assign w_reject = (r_state == S_IDLE) && start && !w_len_ok;
    assign w_xfer   = (r_state == S_SEND) && out_ready;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: one DONE cycle separates headers so done is a clean pulse.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_SEND;
            S_SEND:  if (w_xfer && (r_idx == 3'd7)) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Capture header fields on accept; the length is finalised here so later
    // input changes cannot disturb the bytes in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_src <= 16'h0000;
            r_dst <= 16'h0000;
            r_len <= 16'h0000;
        end else if (w_accept) begin
            r_src <= src_port;
            r_dst <= dst_port;
            r_len <= payload_len + 16'd8;
        end
    end

    // Byte index: cleared on accept, advanced per handshake; wraps to 0 after byte 7.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx <= 3'd0;
        end else if (w_accept) begin
            r_idx <= 3'd0;
        end else if (w_xfer) begin
            r_idx <= r_idx + 3'd1;
        end
    end

    // Registered one-cycle pulse for a start rejected on an oversize length.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_len_err <= 1'b0;
        end else begin
            r_len_err <= w_reject;
        end
    end

    // Header byte selection, MSB-first per 16-bit field.
    always_comb begin
        w_byte = 8'h00;
        case (r_idx)
            3'd0: w_byte = r_src[15:8];
            3'd1: w_byte = r_src[7:0];
            3'd2: w_byte = r_dst[15:8];
            3'd3: w_byte = r_dst[7:0];
            3'd4: w_byte = r_len[15:8];
            3'd5: w_byte = r_len[7:0];
            3'd6: w_byte = CSUM[15:8];
            3'd7: w_byte = CSUM[7:0];
            default: w_byte = 8'h00;
        endcase
    end

    // Outputs decode straight from registered state, so reset clears them at once.
    assign out_valid = (r_state == S_SEND);
    assign busy      = (r_state == S_SEND);
    assign done      = (r_state == S_DONE);
    assign len_err   = r_len_err;
    assign eth_data  = (r_state == S_SEND) ? w_byte : 8'h00;
    assign out_cnt   = (r_state == S_SEND) ? (START + {5'd0, r_idx}) : 8'h00;

endmodule
